// File: rtl/hardsigmoid_rr_scheduler.sv
// Round-robin scheduler sharing one pipelined HardSigmoid unit among NUM_REQ requesters,
// with bounded bursts, a LAT-deep result tag pipeline, flush/drain and a sticky protocol flag.
module hardsigmoid_rr_scheduler #(
   parameter int NUM_REQ   = 4,
   parameter int DW        = 32,
   parameter int LAT       = 3,
   parameter int MAX_BURST = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*DW-1:0] req_data,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [DW-1:0]         rsp_data,
   output logic                  hs_valid_in,
   output logic [DW-1:0]         hs_input_data,
   input  logic                  hs_valid_out,
   input  logic [DW-1:0]         hs_output_data,
   input  logic                  flush_req,
   output logic                  flush_done,
   output logic                  busy,
   output logic                  proto_err,
   output logic [1:0]            dbg_state
);

   // Handshake: a beat moves when req_valid[i] & req_ready[i] on a rising edge; ready is
   // only ever raised toward a requester whose valid is already high, and responses have no
   // backpressure (rsp_valid is a one-cycle strobe the owner must take).

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam int FW = $clog2(LAT + 1);
   localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
   localparam logic [IW-1:0] LAST_ID   = IW'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_FLUSH = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic            own_q, own_d;
   logic [CW-1:0]   burst_q, burst_d;
   logic [FW-1:0]   inflight_q, inflight_d;
   logic [LAT-1:0]  tag_v_q;
   logic [IW-1:0]   tag_id_q [LAT];
   logic            proto_err_q;

   logic            grant_vld;
   logic [IW-1:0]   grant_id;
   logic            hold;
   logic [IW-1:0]   cand;
   logic            retire;

   function automatic logic [IW-1:0] next_id(input logic [IW-1:0] id);
      return (id == LAST_ID) ? '0 : id + 1'b1;
   endfunction

   assign retire = tag_v_q[LAT-1];

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      owner_d   = owner_q;
      own_d     = own_q;
      burst_d   = burst_q;
      grant_vld = 1'b0;
      grant_id  = '0;
      hold      = 1'b0;
      cand      = rr_ptr_q;
      case (state_q)
         S_IDLE: begin
            if (flush_req)       state_d = S_FLUSH;
            else if (|req_valid) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (flush_req) begin
               state_d = S_FLUSH;
               own_d   = 1'b0;
               burst_d = '0;
               if (own_q) rr_ptr_d = next_id(owner_q);
            end else begin
               hold = own_q && req_valid[owner_q] && (burst_q < BURST_MAX);
               if (hold) begin
                  grant_vld = 1'b1;
                  grant_id  = owner_q;
                  burst_d   = burst_q + 1'b1;
               end else begin
                  // Releasing owner hands the pointer on and a successor is picked this cycle.
                  if (own_q) begin
                     cand     = next_id(owner_q);
                     rr_ptr_d = next_id(owner_q);
                  end
                  for (int k = 0; k < NUM_REQ; k++) begin
                     if (!grant_vld && req_valid[cand]) begin
                        grant_vld = 1'b1;
                        grant_id  = cand;
                     end
                     cand = next_id(cand);
                  end
                  if (grant_vld) begin
                     own_d   = 1'b1;
                     owner_d = grant_id;
                     burst_d = CW'(1);
                  end else begin
                     own_d   = 1'b0;
                     burst_d = '0;
                     state_d = S_IDLE;
                  end
               end
            end
         end
         S_FLUSH: begin
            if (!flush_req && (inflight_q == '0)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      inflight_d = inflight_q;
      if (grant_vld && !retire)      inflight_d = inflight_q + 1'b1;
      else if (!grant_vld && retire) inflight_d = inflight_q - 1'b1;
   end

   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = grant_vld && (grant_id == IW'(i));
         rsp_valid[i] = retire && (tag_id_q[LAT-1] == IW'(i));
      end
   end

   assign hs_valid_in   = grant_vld;
   assign hs_input_data = grant_vld ? req_data[grant_id*DW +: DW] : '0;
   assign rsp_data      = retire ? hs_output_data : '0;
   assign flush_done    = (state_q == S_FLUSH) && (inflight_q == '0);
   assign busy          = (inflight_q != '0) || (state_q != S_IDLE);
   assign proto_err     = proto_err_q;
   assign dbg_state     = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         own_q       <= 1'b0;
         burst_q     <= '0;
         inflight_q  <= '0;
         tag_v_q     <= '0;
         proto_err_q <= 1'b0;
         for (int k = 0; k < LAT; k++) tag_id_q[k] <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         own_q      <= own_d;
         burst_q    <= burst_d;
         inflight_q <= inflight_d;
         tag_v_q[0]  <= grant_vld;
         tag_id_q[0] <= grant_id;
         for (int k = 1; k < LAT; k++) begin
            tag_v_q[k]  <= tag_v_q[k-1];
            tag_id_q[k] <= tag_id_q[k-1];
         end
         // The shared unit must agree with our tag record on every retire slot.
         if (hs_valid_out != retire) proto_err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_hardsigmoid_rr_scheduler.sv
// Randomized bench for hardsigmoid_rr_scheduler: a behavioural arbiter model predicts every
// grant, a stand-in HardSigmoid unit closes the loop, and a monitor checks routed responses.
module tb_hardsigmoid_rr_scheduler;
   localparam int NUM_REQ = 4;
   localparam int DW = 32;
   localparam int LAT = 3;
   localparam int MAX_BURST = 4;
   localparam int EW = 40 + DW;

   logic clk = 1'b0;
   logic rst;
   logic [NUM_REQ-1:0] req_valid, req_ready, rsp_valid;
   logic [NUM_REQ*DW-1:0] req_data;
   logic [DW-1:0] rsp_data, hs_input_data, hs_output_data;
   logic hs_valid_in, hs_valid_out, flush_req, flush_done, busy, proto_err;
   logic [1:0] dbg_state;

   hardsigmoid_rr_scheduler #(.NUM_REQ(NUM_REQ), .DW(DW), .LAT(LAT), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .hs_valid_in(hs_valid_in),
      .hs_input_data(hs_input_data), .hs_valid_out(hs_valid_out), .hs_output_data(hs_output_data),
      .flush_req(flush_req), .flush_done(flush_done), .busy(busy), .proto_err(proto_err),
      .dbg_state(dbg_state));

   // ---------------- clock / reset / bookkeeping ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;
   logic [EW-1:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Q16.16 HardSigmoid: clamp(x/6 + 0.5, 0, 1)
   function automatic logic [DW-1:0] hs_fn(input logic [DW-1:0] x);
      int sx;
      sx = int'($signed(x));
      if (sx >= 196608) return 32'h0001_0000;
      if (sx <= -196608) return '0;
      return DW'(sx / 6 + 32768);
   endfunction

   // ---------------- stand-in shared HardSigmoid unit ----------------
   logic u_v [LAT];
   logic [DW-1:0] u_d [LAT];
   logic drop_now = 1'b0;
   logic drop_pending = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < LAT; k++) begin u_v[k] <= 1'b0; u_d[k] <= '0; end
      end else begin
         u_v[0] <= hs_valid_in;
         u_d[0] <= hs_input_data;
         for (int k = 1; k < LAT; k++) begin u_v[k] <= u_v[k-1]; u_d[k] <= u_d[k-1]; end
      end
   end
   always_comb begin
      hs_valid_out = u_v[LAT-1] & ~drop_now;
      hs_output_data = hs_fn(u_d[LAT-1]);
   end

   // ---------------- behavioural reference model ----------------
   logic drv_valid [NUM_REQ];
   logic [DW-1:0] drv_data [NUM_REQ];
   int m_state = 0;            // 0 idle, 1 issuing, 2 flushing
   int m_ptr = 0, m_owner = 0, m_cnt = 0;
   bit m_own = 0, m_proto = 0;
   logic [LAT-1:0] m_hist = '0; // beats of the last LAT cycles, newest in bit 0
   logic [NUM_REQ-1:0] m_beat_vec = '0;

   always @(negedge clk) begin
      int grant, start, idx, infl;
      bit held;
      if (rst) begin
         chk("rst_req_ready", req_ready, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp_data", rsp_data, 0);
         chk("rst_hs_valid_in", hs_valid_in, 0);
         chk("rst_hs_input_data", hs_input_data, 0);
         chk("rst_busy", busy, 0);
         chk("rst_flush_done", flush_done, 0);
         chk("rst_proto_err", proto_err, 0);
         m_state = 0; m_ptr = 0; m_owner = 0; m_cnt = 0; m_own = 0; m_proto = 0;
         m_hist = '0; m_beat_vec = '0;
      end else begin
         grant = -1;
         held = 0;
         infl = $countones(m_hist);
         if (m_state == 1 && !flush_req) begin
            if (m_own && req_valid[m_owner] && m_cnt < MAX_BURST) begin
               grant = m_owner;
               held = 1;
            end else begin
               start = m_own ? (m_owner + 1) % NUM_REQ : m_ptr;
               for (int k = 0; k < NUM_REQ; k++) begin
                  idx = (start + k) % NUM_REQ;
                  if (grant < 0 && req_valid[idx]) grant = idx;
               end
            end
         end
         chk("req_ready", req_ready, (grant >= 0) ? (64'd1 << grant) : 64'd0);
         chk("hs_valid_in", hs_valid_in, (grant >= 0) ? 1 : 0);
         if (grant >= 0) begin
            chk("hs_input_data", hs_input_data, drv_data[grant]);
            exp_q.push_back({32'(cyc + LAT), 8'(grant), hs_fn(drv_data[grant])});
         end
         chk("flush_done", flush_done, (m_state == 2 && infl == 0) ? 1 : 0);
         chk("busy", busy, (m_state != 0 || infl != 0) ? 1 : 0);
         chk("proto_err", proto_err, m_proto);
         if (hs_valid_out != m_hist[LAT-1]) m_proto = 1;
         case (m_state)
            0: if (flush_req) m_state = 2; else if (|req_valid) m_state = 1;
            1: begin
               if (flush_req) begin
                  if (m_own) m_ptr = (m_owner + 1) % NUM_REQ;
                  m_own = 0; m_state = 2;
               end else if (held) begin
                  m_cnt++;
               end else begin
                  if (m_own) m_ptr = (m_owner + 1) % NUM_REQ;
                  if (grant >= 0) begin m_own = 1; m_owner = grant; m_cnt = 1; end
                  else begin m_own = 0; m_cnt = 0; m_state = 0; end
               end
            end
            default: if (!flush_req && infl == 0) m_state = 0;
         endcase
         m_hist = {m_hist[LAT-2:0], (grant >= 0)};
         m_beat_vec = (grant >= 0) ? NUM_REQ'(1 << grant) : '0;
      end
   end

   // ---------------- response monitor ----------------
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (rst) begin
         exp_q.delete();
      end else if (exp_q.size() != 0 && int'(exp_q[0][EW-1:40]) == cyc) begin
         e = exp_q.pop_front();
         chk("rsp_valid", rsp_valid, 64'd1 << e[39:32]);
         chk("rsp_data", rsp_data, e[DW-1:0]);
      end else begin
         chk("rsp_idle", rsp_valid, 0);
      end
   end

   // ---------------- driver ----------------
   function automatic logic [DW-1:0] rand_data();
      if ($urandom_range(0, 3) == 0) return $urandom;
      return DW'(int'($urandom_range(0, 524288)) - 262144);
   endfunction

   task automatic apply_inputs();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i] = drv_valid[i];
         req_data[i*DW +: DW] = drv_data[i];
      end
   endtask

   task automatic step(input logic [NUM_REQ-1:0] mask, input int p_new, input int p_raise);
      @(posedge clk);
      #1;
      drop_now = 1'b0;
      if (drop_pending && u_v[LAT-1]) begin drop_now = 1'b1; drop_pending = 1'b0; end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (m_beat_vec[i]) begin
            drv_valid[i] = mask[i] && ($urandom_range(0, 99) < p_new);
            drv_data[i] = rand_data();
         end else if (!drv_valid[i] && mask[i] && ($urandom_range(0, 99) < p_raise)) begin
            drv_valid[i] = 1'b1;
            drv_data[i] = rand_data();
         end
      end
      apply_inputs();
   endtask

   task automatic run(input int n, input logic [NUM_REQ-1:0] mask, input int p_new, input int p_raise);
      for (int c = 0; c < n; c++) step(mask, p_new, p_raise);
   endtask

   initial begin
      rst = 1'b1;
      flush_req = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin drv_valid[i] = 1'b0; drv_data[i] = '0; end
      apply_inputs();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // single requester 0, operand 3
      drv_valid[0] = 1'b1;
      drv_data[0] = 32'h0000_0003;
      apply_inputs();
      run(8, 4'b0001, 0, 0);

      // all requesters continuously valid
      for (int i = 0; i < NUM_REQ; i++) begin drv_valid[i] = 1'b1; drv_data[i] = rand_data(); end
      apply_inputs();
      run(24, 4'b1111, 100, 100);

      // random traffic with drops and re-raises
      run(300, 4'b1111, 60, 30);
      run(100, 4'b0110, 50, 50);

      // flush with work in flight, then resume
      run(6, 4'b1111, 100, 100);
      flush_req = 1'b1;
      run(10, 4'b1111, 80, 50);
      flush_req = 1'b0;
      run(40, 4'b1111, 60, 40);

      // shared unit drops one result
      drop_pending = 1'b1;
      for (int c = 0; c < 40 && drop_pending; c++) step(4'b1111, 80, 60);
      chk("drop_applied", drop_pending, 0);
      run(30, 4'b1111, 60, 40);

      // asynchronous reset mid-burst
      for (int i = 0; i < NUM_REQ; i++) drv_valid[i] = 1'b1;
      apply_inputs();
      run(6, 4'b1111, 100, 100);
      #2 rst = 1'b1;
      #1;
      chk("async_req_ready", req_ready, 0);
      chk("async_rsp_valid", rsp_valid, 0);
      chk("async_hs_valid_in", hs_valid_in, 0);
      chk("async_busy", busy, 0);
      chk("async_proto_err", proto_err, 0);
      run(2, 4'b1111, 0, 0);
      rst = 1'b0;
      run(40, 4'b1111, 70, 40);

      // drain
      for (int i = 0; i < NUM_REQ; i++) drv_valid[i] = 1'b0;
      apply_inputs();
      run(LAT + 6, 4'b0000, 0, 0);
      chk("drained", exp_q.size(), 0);
      chk("idle_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
